serial_word_deframer: RTL and testbench
=======================================

# serial_word_deframer

Serial-to-parallel receive stage that consumes the one-bit-per-clock stream produced by the upstream serial shift register. It hunts for a sync pattern, then assembles a fixed number of MSB-first data words and presents each as a parallel word with a one-cycle valid strobe. After the frame completes it returns to hunting.

## Interface
- SYNC_W, 8: width of the sync pattern in bits.
- SYNC_PATTERN, 8'hA5: pattern that opens a frame; compared MSB-first.
- DATA_W, 8: bits per data word.
- FRAME_WORDS, 4: data words per frame; minimum 1.
- clk  input  1  rising-edge clock; one serial bit is sampled every edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- d  input  1  serial data bit from the upstream stage.
- dout  output  DATA_W  last completed word; first received bit lands in dout[DATA_W-1].
- dout_valid  output  1  one-cycle pulse when dout updates.
- locked  output  1  high while inside a frame, after sync and before the last word.
- frame_done  output  1  one-cycle pulse coincident with dout_valid of the final word of a frame.

## Operation
- Two states: HUNT (reset state) and LOCK.
- HUNT:
  - A SYNC_W-bit history register shifts left every edge, with d entering at bit 0.
  - Match condition: {hist[SYNC_W-2:0], d} == SYNC_PATTERN at an edge. On a match, go to LOCK at that edge and clear the bit and word counters.
  - Overlapping patterns are detected. A match may complete on any bit, not only on word boundaries.
- LOCK:
  - d shifts into a DATA_W-bit assembly register, MSB-first.
  - The bit counter runs 0..DATA_W-1.
  - At the edge sampling bit DATA_W-1:
    - dout <= {assembly[DATA_W-2:0], d}.
    - dout_valid <= 1.
    - The bit counter wraps to 0 and the word counter increments.
- Sync-pattern bits appearing inside data are treated as data. There is no re-sync while locked.
- Frame end: at the edge completing word FRAME_WORDS-1 (counting from 0):
  - frame_done <= 1 and locked <= 0.
  - State returns to HUNT.
  - hist is cleared to 0, so a new frame needs SYNC_W fresh bits. This holds unless SYNC_PATTERN is 0, which is a disallowed parameter value.
- dout holds its value between valid pulses.
- dout_valid and frame_done are 0 in every other cycle.
- Reset (any time, including mid-word or mid-frame):
  - dout, dout_valid, locked and frame_done go to 0 asynchronously.
  - State goes to HUNT; hist and all counters go to 0.
  - Reset is deasserted synchronously by the upstream reset logic.

## Timing
- locked rises in the cycle after the edge that samples the last sync bit.
- The first data bit is sampled on the next edge after that.
- Word latency: dout and dout_valid are visible in the cycle after the edge sampling the word's last bit. No extra pipeline stage.
- Frame length after sync: exactly FRAME_WORDS*DATA_W edges.
  - With defaults, locked is high for 32 cycles.
  - frame_done and locked-fall occur on the same edge as the final dout_valid.
- Back-to-back frames: the earliest next lock is SYNC_W edges after frame_done.
- Counter widths: $clog2(DATA_W) and $clog2(FRAME_WORDS), minimum 1 bit each. Counters never exceed their terminal values.

## Structure
- Shared package deframer_pkg:
  - State enum {HUNT, LOCK}.
  - Default constants SYNC_PATTERN_DEF = 8'hA5, DATA_W_DEF = 8, FRAME_WORDS_DEF = 4.
- Natural sub-module: deframer_sipo.
  - A DATA_W-bit serial-in/parallel-out register with a bit counter.
  - Produces the full word and a word_done pulse.
  - Top level holds the state machine, the sync history register and the word counter.
- All sequential logic uses non-blocking assignments in a single clocked, async-reset process per register group.

## Test plan
All scenarios use SYNC_PATTERN = 8'hA5, DATA_W = 8, FRAME_WORDS = 2, and MSB-first serial bits.
- Reset: hold reset = 0 for 5 cycles while toggling d -> dout = 0, dout_valid = 0, locked = 0, frame_done = 0 throughout.
- Basic frame: after reset = 1, send 8'hA5, 8'h3C, 8'hC3.
  - locked rises after bit 8.
  - dout = 8'h3C with dout_valid after bit 16.
  - dout = 8'hC3 with dout_valid and frame_done after bit 24; locked = 0 afterwards.
- Overlap/noise: send 8'hFF, then bits 1010_1010_0101 -> no lock on the noise; locked rises after the 12th pattern bit.
- Data containing the pattern: sync, then 8'hA5, 8'hA5 -> both delivered as data words; frame_done on the second; no early relock.
- Mid-word reset: sync, 3 data bits, then reset pulse low for 1 cycle -> all outputs 0 immediately; a subsequent 8'h3C without a new sync produces no dout_valid.
- Back-to-back: frame 1 immediately followed by 8'hA5, 8'h11, 8'h22 -> locked re-rises 8 edges after frame_done; dout = 8'h11 then 8'h22.

Source files
------------

// File: rtl/deframer_pkg.sv
// Shared types and defaults for the serial word deframer.
package deframer_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } deframer_state_e;

  localparam logic [7:0]  SYNC_PATTERN_DEF = 8'hA5;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned FRAME_WORDS_DEF  = 4;

  // Counter width for a count of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deframer_sipo.sv
// MSB-first serial-in/parallel-out word assembler with a bit counter.
module deframer_sipo
  import deframer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_en_i,
  input  logic              clr_i,
  input  logic              d_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o,
  output logic              last_bit_o
);

  localparam int unsigned         BitCntW = cnt_width(DATA_W);
  localparam logic [BitCntW-1:0]  LastBit = BitCntW'(DATA_W - 1);

  logic [DATA_W-1:0]  asm_q, asm_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               word_done_q, word_done_d;

  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    word_done_d = 1'b0;
    last_bit_o  = shift_en_i && !clr_i && (cnt_q == LastBit);
    if (clr_i) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (shift_en_i) begin
      asm_d = {asm_q[DATA_W-2:0], d_i};
      if (cnt_q == LastBit) begin
        cnt_d       = '0;
        word_d      = {asm_q[DATA_W-2:0], d_i};
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      word_done_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      word_done_q <= word_done_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = word_done_q;

endmodule

// File: rtl/serial_word_deframer.sv
// Hunts for a sync pattern in a serial stream, then emits FRAME_WORDS parallel words.
module serial_word_deframer
  import deframer_pkg::*;
#(
  parameter int unsigned       SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF),
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       FRAME_WORDS  = FRAME_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              locked,
  output logic              frame_done
);

  localparam int unsigned         WordCntW = cnt_width(FRAME_WORDS);
  localparam logic [WordCntW-1:0] LastWord = WordCntW'(FRAME_WORDS - 1);

  deframer_state_e     state_q, state_d;
  logic [SYNC_W-1:0]   hist_q, hist_d;
  logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
  logic                frame_done_q, frame_done_d;

  logic [SYNC_W-1:0]   hist_shift;
  logic                shift_en;
  logic                sipo_clr;
  logic                last_bit;

  deframer_sipo #(
    .DATA_W (DATA_W)
  ) u_sipo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .shift_en_i  (shift_en),
    .clr_i       (sipo_clr),
    .d_i         (d),
    .word_o      (dout),
    .word_done_o (dout_valid),
    .last_bit_o  (last_bit)
  );

  assign hist_shift = {hist_q[SYNC_W-2:0], d};

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    shift_en     = 1'b0;
    sipo_clr     = 1'b0;
    unique case (state_q)
      HUNT: begin
        hist_d = hist_shift;
        if (hist_shift == SYNC_PATTERN) begin
          state_d    = LOCK;
          word_cnt_d = '0;
          sipo_clr   = 1'b1;
        end
      end
      LOCK: begin
        shift_en = 1'b1;
        if (last_bit) begin
          if (word_cnt_q == LastWord) begin
            // Clearing the history forces a full fresh sync before the next frame.
            state_d      = HUNT;
            hist_d       = '0;
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      hist_q       <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign locked     = (state_q == LOCK);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_word_deframer.sv
// Directed bench for serial_word_deframer with FRAME_WORDS = 2.
module tb_serial_word_deframer;

  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_word_deframer #(
    .SYNC_W       (8),
    .SYNC_PATTERN (8'hA5),
    .DATA_W       (8),
    .FRAME_WORDS  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Packed view {dout, dout_valid, locked, frame_done}.
  function automatic logic [31:0] st();
    return {21'd0, dout, dout_valid, locked, frame_done};
  endfunction

  function automatic logic [31:0] ex(input logic [7:0] w, input logic v, input logic l,
                                     input logic f);
    return {21'd0, w, v, l, f};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    d = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  logic seen;

  initial begin
    reset = 1'b0;
    d     = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d = ~d;
      @(posedge clk);
      #1;
      check("reset_hold", st(), ex(8'h00, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    d     = 1'b0;

    // Basic frame: A5, 3C, C3
    send_bits(32'h52, 7);
    check("basic_prelock", {31'd0, locked}, 32'd0);
    send_bit(1'b1);
    check("basic_lock", st(), ex(8'h00, 0, 1, 0));
    send_bits(32'h1E, 7);
    check("basic_w0_mid", st(), ex(8'h00, 0, 1, 0));
    send_bit(1'b0);
    check("basic_w0", st(), ex(8'h3C, 1, 1, 0));
    send_bits(32'h61, 7);
    check("basic_w1_mid", st(), ex(8'h3C, 0, 1, 0));
    send_bit(1'b1);
    check("basic_w1", st(), ex(8'hC3, 1, 0, 1));
    send_bit(1'b0);
    check("basic_after", st(), ex(8'hC3, 0, 0, 0));

    // Noise then a pattern completing off a byte boundary
    send_bits(32'hFF, 8);
    check("noise_ff", st(), ex(8'hC3, 0, 0, 0));
    send_bits(32'h552, 11);
    check("overlap_11", st(), ex(8'hC3, 0, 0, 0));
    send_bit(1'b1);
    check("overlap_12", st(), ex(8'hC3, 0, 1, 0));
    send_bits(32'h5A, 8);
    check("overlap_w0", st(), ex(8'h5A, 1, 1, 0));
    send_bits(32'h69, 8);
    check("overlap_w1", st(), ex(8'h69, 1, 0, 1));

    // Data words equal to the sync pattern
    send_bits(32'hA5, 8);
    check("pat_lock", st(), ex(8'h69, 0, 1, 0));
    send_bits(32'hA5, 8);
    check("pat_w0", st(), ex(8'hA5, 1, 1, 0));
    send_bits(32'hA5, 8);
    check("pat_w1", st(), ex(8'hA5, 1, 0, 1));
    send_bits(32'h00, 8);
    check("pat_no_relock", st(), ex(8'hA5, 0, 0, 0));

    // Reset in the middle of a word
    send_bits(32'hA5, 8);
    send_bits(32'h5, 3);
    check("mid_locked", st(), ex(8'hA5, 0, 1, 0));
    #2;
    reset = 1'b0;
    #1;
    check("mid_async", st(), ex(8'h00, 0, 0, 0));
    @(posedge clk);
    #1;
    check("mid_hold", st(), ex(8'h00, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(i[0] ? 1'b0 : 1'b0);
      seen = seen | dout_valid | locked;
    end
    seen = 1'b0;
    send_bits(32'h00, 0);
    // 3C without sync must produce nothing
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h3C;
      send_bit(w[i]);
      seen = seen | dout_valid | locked;
    end
    check("mid_no_valid", {31'd0, seen}, 32'd0);
    check("mid_dout", {24'd0, dout}, 32'h00);

    // Back-to-back frames
    send_bits(32'h00, 8);
    send_bits(32'hA5, 8);
    check("b2b_lock1", st(), ex(8'h00, 0, 1, 0));
    send_bits(32'h5A, 8);
    send_bits(32'hC3, 8);
    check("b2b_f1_end", st(), ex(8'hC3, 1, 0, 1));
    send_bits(32'h52, 7);
    check("b2b_7", st(), ex(8'hC3, 0, 0, 0));
    send_bit(1'b1);
    check("b2b_relock", st(), ex(8'hC3, 0, 1, 0));
    send_bits(32'h11, 8);
    check("b2b_w0", st(), ex(8'h11, 1, 1, 0));
    send_bits(32'h22, 8);
    check("b2b_w1", st(), ex(8'h22, 1, 0, 1));
    send_bit(1'b0);
    check("b2b_after", st(), ex(8'h22, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
